// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle execute-stage ALU.
//   - 4-bit pre-decoded opcodes supplied by the decoder
//   - top-level FSM state encoding
//   - operating mode of the iterative multiply/divide datapath
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_LI  = 4'd8;
  localparam logic [3:0] OP_B   = 4'd9;
  localparam logic [3:0] OP_BNZ = 4'd10;
  localparam logic [3:0] OP_BZ  = 4'd11;
  localparam logic [3:0] OP_BGE = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;
  localparam logic [3:0] OP_DIV = 4'd14;
  localparam logic [3:0] OP_REM = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    IT_MUL = 2'd0,
    IT_DIV = 2'd1,
    IT_REM = 2'd2
  } iter_mode_e;

endpackage

// File: rtl/alu_iter.sv
// alu_iter: shared iterative datapath, one bit per cycle.
//   MUL : LSB-first shift-add, low WIDTH bits of a*b.
//   DIV/REM : restoring division, quotient in opa, remainder in acc.
// Ports:
//   CLK, RST        clock, synchronous active-high reset (control only)
//   start, mode     load operands a/b and begin WIDTH iterations
//   abort           drop the in-flight operation
//   a, b            operands sampled on start
//   done            high during the final iteration; result valid next cycle
//   result          MUL product, DIV quotient or REM remainder
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  iter_mode_e       mode,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             running_q, running_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  iter_mode_e       mode_q, mode_d;

  // Partial remainder shifted left with the next dividend bit. The extra
  // top bit keeps the trial subtraction's borrow.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  always_comb begin
    running_d = running_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    mode_d    = mode_q;
    rem_sh    = {acc_q, opa_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, opb_q};

    if (abort) begin
      running_d = 1'b0;
      count_d   = '0;
    end else if (start) begin
      running_d = 1'b1;
      count_d   = CNT_W'(WIDTH - 1);
      acc_d     = '0;
      opa_d     = a;
      opb_d     = b;
      mode_d    = mode;
    end else if (running_q) begin
      if (mode_q == IT_MUL) begin
        if (opb_q[0]) begin
          acc_d = acc_q + opa_q;
        end
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end else begin
        // Restore (keep the shifted remainder) when the trial subtraction borrows.
        if (!diff[WIDTH]) begin
          acc_d = diff[WIDTH-1:0];
          opa_d = {opa_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
          opa_d = {opa_q[WIDTH-2:0], 1'b0};
        end
      end
      if (count_q == '0) begin
        running_d = 1'b0;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Control registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      running_q <= 1'b0;
      count_q   <= '0;
    end else begin
      running_q <= running_d;
      count_q   <= count_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    acc_q  <= acc_d;
    opa_q  <= opa_d;
    opb_q  <= opb_d;
    mode_q <= mode_d;
  end

  assign done = running_q && (count_q == '0);

  always_comb begin
    unique case (mode_q)
      IT_DIV:  result = opa_q;
      default: result = acc_q;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU.
//   Single-cycle ALU/branch ops return one cycle after acceptance; MUL/DIV/REM
//   run on alu_iter for WIDTH cycles plus one result cycle.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   in_valid/in_ready accept handshake; in_ready high only in IDLE
//   op, sr1, sr2      opcode and register operands
//   pc, imm           PC of the instruction and sign-extended immediate
//   flush             abort in-flight op, block acceptance this cycle
//   q, q_valid        result / branch target with one-cycle valid pulse
//   taken, dz         branch taken, divide-by-zero (valid with q_valid)
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] sr1,
  input  logic [WIDTH-1:0] sr2,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             taken,
  output logic             dz
);

  localparam int SH_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             taken_q, taken_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             iter_start;
  logic             iter_abort;
  iter_mode_e       iter_mode;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;

  logic signed [WIDTH-1:0] sr1_s;
  logic signed [WIDTH-1:0] sr2_s;
  logic [WIDTH-1:0]        target;
  logic                    ge;

  assign sr1_s    = $signed(sr1);
  assign sr2_s    = $signed(sr2);
  assign target   = pc + imm;
  assign ge       = SIGNED_CMP ? (sr1_s >= sr2_s) : (sr1 >= sr2);
  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    unique case (op)
      OP_MUL:  iter_mode = IT_MUL;
      OP_DIV:  iter_mode = IT_DIV;
      default: iter_mode = IT_REM;
    endcase
  end

  alu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .CLK    (CLK),
    .RST    (RST),
    .start  (iter_start),
    .mode   (iter_mode),
    .abort  (iter_abort),
    .a      (sr1),
    .b      (sr2),
    .done   (iter_done),
    .result (iter_result)
  );

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    q_valid_d  = 1'b0;
    taken_d    = 1'b0;
    dz_d       = 1'b0;
    iter_start = 1'b0;
    iter_abort = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          q_valid_d = 1'b1;
          unique case (op)
            OP_ADD: q_d = sr1 + sr2;
            OP_SUB: q_d = sr1 - sr2;
            OP_AND: q_d = sr1 & sr2;
            OP_OR:  q_d = sr1 | sr2;
            OP_XOR: q_d = sr1 ^ sr2;
            OP_SLL: q_d = sr1 << sr2[SH_W-1:0];
            OP_SRL: q_d = sr1 >> sr2[SH_W-1:0];
            OP_LI:  q_d = imm;
            OP_B: begin
              q_d     = target;
              taken_d = 1'b1;
            end
            OP_BNZ: begin
              taken_d = (sr1 != '0);
              q_d     = (sr1 != '0) ? target : pc;
            end
            OP_BZ: begin
              taken_d = (sr1 == '0);
              q_d     = (sr1 == '0) ? target : pc;
            end
            OP_BGE: begin
              taken_d = ge;
              q_d     = ge ? target : pc;
            end
            OP_MUL, OP_DIV, OP_REM: begin
              if (sr2 == '0) begin
                // Zero second operand resolves immediately, no iteration.
                if (op == OP_DIV) begin
                  q_d  = '1;
                  dz_d = 1'b1;
                end else if (op == OP_REM) begin
                  q_d  = sr1;
                  dz_d = 1'b1;
                end else begin
                  q_d  = '0;
                end
              end else begin
                q_valid_d  = 1'b0;
                iter_start = 1'b1;
                state_d    = BUSY;
              end
            end
            default: ; // NOP: pulse q_valid, hold q
          endcase
        end
      end
      BUSY: begin
        if (flush) begin
          iter_abort = 1'b1;
          state_d    = IDLE;
        end else if (iter_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!flush) begin
          q_d       = iter_result;
          q_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / state register boundary.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      taken_q   <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      taken_q   <= taken_d;
      dz_q      <= dz_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign taken   = taken_q;
  assign dz      = dz_q;

endmodule
